fp_int_mul_seq: RTL

- Bit-serial job sequencer in front of fp_int_mul.
- Accepts one job per handshake: an fp16 activation, an integer weight of up to 8 bits, and a precision.
- Streams the weight MSB-first, one bit per cycle, while holding the activation and precision stable, so the multiplier sees one contiguous valid burst per job.
- One-entry pending buffer plus one active slot allows back-to-back jobs with no valid gap.

---
 rtl/fp_int_mul_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fp_int_mul_seq.sv
// Bit-serial job sequencer for fp_int_mul: one PEND slot plus one ACT slot stream weights MSB-first.
// Latency: first bit two cycles after acceptance when idle, else immediately after the previous job's last bit.
// Backpressure: in_ready = !pend_valid | take, forced low by flush; optional counters under FP_INT_SEQ_PERF_EN.
module fp_int_mul_seq #(
   parameter int ACT_WIDTH     = 16,
   parameter int MAX_PRECISION = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ACT_WIDTH-1:0]     in_act,
   input  logic [MAX_PRECISION-1:0] in_wgt,
   input  logic [3:0]               in_prec,
   input  logic                     flush,
   output logic                     mul_valid,
   output logic [ACT_WIDTH-1:0]     mul_act,
   output logic                     mul_w,
   output logic [3:0]               mul_precision,
   output logic                     job_first,
   output logic                     job_last,
   output logic                     busy,
   output logic                     prec_err
`ifdef FP_INT_SEQ_PERF_EN
   ,
   input  logic                     perf_clr,
   output logic [31:0]              perf_jobs,
   output logic [31:0]              perf_bits,
   output logic [31:0]              perf_stall
`endif
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t                   state_q, state_d;
   logic                     pend_valid;
   logic [ACT_WIDTH-1:0]     pend_act, act_a;
   logic [MAX_PRECISION-1:0] pend_wgt, wgt_a;
   logic [3:0]               pend_prec, prec_a;
   logic [2:0]               bit_cnt, bit_cnt_d;
   logic [2:0]               w_idx;
   logic                     last, take, accept, prec_bad;
   logic [3:0]               prec_san;

   assign last     = (state_q == S_RUN) && ((prec_a - 4'd1) == {1'b0, bit_cnt});
   assign take     = pend_valid && ((state_q == S_IDLE) || last);
   assign in_ready = !flush && (!pend_valid || take);
   assign accept   = in_valid && in_ready;
   assign busy     = pend_valid || (state_q == S_RUN);

   assign prec_bad = (in_prec == 4'd0) || (in_prec > 4'(MAX_PRECISION));
   assign prec_san = prec_bad ? 4'(MAX_PRECISION) : in_prec;

   // prec 8 wraps to index 0 in 3 bits, so the subtraction still lands on the MSB.
   assign w_idx = prec_a[2:0] - 3'd1 - bit_cnt;

   // act_a/prec_a only change on take, so they naturally hold while idle.
   assign mul_act       = act_a;
   assign mul_precision = prec_a;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt;
      mul_valid = 1'b0;
      mul_w     = 1'b0;
      job_first = 1'b0;
      job_last  = 1'b0;
      if (state_q == S_RUN) begin
         mul_valid = 1'b1;
         mul_w     = wgt_a[w_idx];
         job_first = (bit_cnt == 3'd0);
         job_last  = last;
      end
      if (flush) begin
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
      end else if (take) begin
         state_d   = S_RUN;
         bit_cnt_d = 3'd0;
      end else if (last) begin
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
      end else if (state_q == S_RUN) begin
         bit_cnt_d = bit_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         bit_cnt    <= 3'd0;
         pend_valid <= 1'b0;
         pend_act   <= '0;
         pend_wgt   <= '0;
         pend_prec  <= 4'd0;
         act_a      <= '0;
         wgt_a      <= '0;
         prec_a     <= 4'd0;
         prec_err   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_cnt  <= bit_cnt_d;
         prec_err <= accept && prec_bad;
         // A same-edge accept overwrites PEND while its old content moves into ACT.
         if (flush) begin
            pend_valid <= 1'b0;
         end else if (accept) begin
            pend_valid <= 1'b1;
            pend_act   <= in_act;
            pend_wgt   <= in_wgt;
            pend_prec  <= prec_san;
         end else if (take) begin
            pend_valid <= 1'b0;
         end
         if (take && !flush) begin
            act_a  <= pend_act;
            wgt_a  <= pend_wgt;
            prec_a <= pend_prec;
         end
      end
   end

`ifdef FP_INT_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_jobs  <= 32'd0;
         perf_bits  <= 32'd0;
         perf_stall <= 32'd0;
      end else if (perf_clr) begin
         perf_jobs  <= 32'd0;
         perf_bits  <= 32'd0;
         perf_stall <= 32'd0;
      end else begin
         if (take && !flush && (perf_jobs != 32'hFFFF_FFFF))
            perf_jobs <= perf_jobs + 32'd1;
         if (mul_valid && (perf_bits != 32'hFFFF_FFFF))
            perf_bits <= perf_bits + 32'd1;
         if (in_valid && !in_ready && (perf_stall != 32'hFFFF_FFFF))
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule
